ddr2_line_bridge: RTL and testbench

//  Downstream stage of the direct-mapped data cache.
//  - Accepts the cache's single-cycle 128-bit line requests (write-back or line fill).
//  - Queues them in order and replays them on a MIG-style DDR2 user interface (app_*).
//  - Returns read lines to the cache with a one-cycle ddr2_available pulse.
//  - Absorbs the cache's back-to-back "write victim, then read fill" pair without

---
 rtl/ddr2_line_bridge.sv | 176 +++++++++++++++++
 tb/tb_ddr2_line_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_line_bridge.sv
// Line-request bridge between the data cache and a MIG-style DDR2 user interface.
// Requests are queued in order and replayed one controller transaction at a time.
module ddr2_line_bridge #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_SHIFT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ddr2_enable,
    input  logic         ddr2_read,
    input  logic [26:0]  ddr2_addr,
    input  logic [127:0] to_ddr2_data,
    output logic [127:0] ddr2_data,
    output logic         ddr2_available,
    output logic         overflow,
    input  logic         init_calib_complete,
    output logic [26:0]  app_addr,
    output logic [2:0]   app_cmd,
    output logic         app_en,
    input  logic         app_rdy,
    output logic [127:0] app_wdf_data,
    output logic         app_wdf_wren,
    output logic         app_wdf_end,
    output logic [15:0]  app_wdf_mask,
    input  logic         app_wdf_rdy,
    input  logic [127:0] app_rd_data,
    input  logic         app_rd_data_valid
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = 1 + 27 + 128;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_CMD,
        RD_WAIT
    } state_t;

    state_t state, next_state;

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic         full, empty, push, pop;
    logic [ENT_W-1:0] head;
    logic         head_read;
    logic [26:0]  head_addr;
    logic [127:0] head_data;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign head_read = head[ENT_W-1];
    assign head_addr = head[ENT_W-2 -: 27];
    assign head_data = head[127:0];

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push = ddr2_enable && (!full || pop);

    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_mask = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && init_calib_complete) begin
                    pop        = 1'b1;
                    next_state = head_read ? RD_CMD : WR;
                end
            end
            WR: begin
                if ((!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy)) begin
                    next_state = IDLE;
                end
            end
            RD_CMD: begin
                if (app_rdy) begin
                    next_state = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (app_rd_data_valid) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ddr2_read, ddr2_addr, to_ddr2_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            overflow       <= 1'b0;
            ddr2_available <= 1'b0;
            ddr2_data      <= '0;
            app_en         <= 1'b0;
            app_wdf_wren   <= 1'b0;
            app_cmd        <= 3'b001;
            app_addr       <= '0;
            app_wdf_data   <= '0;
        end else begin
            ddr2_available <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (ddr2_enable && !push) begin
                overflow <= 1'b1;
            end

            if (pop) begin
                app_addr <= head_addr >> ADDR_SHIFT;
                app_cmd  <= head_read ? 3'b001 : 3'b000;
                app_en   <= 1'b1;
                if (!head_read) begin
                    app_wdf_wren <= 1'b1;
                    app_wdf_data <= head_data;
                end
            end

            case (state)
                WR: begin
                    if (app_en && app_rdy) begin
                        app_en <= 1'b0;
                    end
                    if (app_wdf_wren && app_wdf_rdy) begin
                        app_wdf_wren <= 1'b0;
                    end
                end
                RD_CMD: begin
                    if (app_rdy) begin
                        app_en <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (app_rd_data_valid) begin
                        ddr2_data      <= app_rd_data;
                        ddr2_available <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr2_line_bridge.sv
// Directed bench for ddr2_line_bridge with a small DDR2 read responder.
module tb_ddr2_line_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic         ddr2_enable;
    logic         ddr2_read;
    logic [26:0]  ddr2_addr;
    logic [127:0] to_ddr2_data;
    logic [127:0] ddr2_data;
    logic         ddr2_available;
    logic         overflow;
    logic         init_calib_complete;
    logic [26:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;

    logic         auto_rsp = 1'b0;
    logic         rsp_valid = 1'b0;
    logic         hs_q;
    logic [127:0] rsp_data = '0;
    logic         man_valid = 1'b0;
    logic [127:0] man_data = '0;

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    logic [29:0]  cmd_q[$];
    logic [127:0] wd_q[$];

    assign app_rd_data_valid = rsp_valid | man_valid;
    assign app_rd_data       = rsp_valid ? rsp_data : man_data;

    ddr2_line_bridge #(.FIFO_DEPTH(4), .ADDR_SHIFT(1)) dut (
        .clk(clk), .rst(rst),
        .ddr2_enable(ddr2_enable), .ddr2_read(ddr2_read), .ddr2_addr(ddr2_addr),
        .to_ddr2_data(to_ddr2_data), .ddr2_data(ddr2_data),
        .ddr2_available(ddr2_available), .overflow(overflow),
        .init_calib_complete(init_calib_complete),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ddr2_available) pulse_cnt++;
        if (app_en && app_rdy) cmd_q.push_back({app_cmd, app_addr});
        if (app_wdf_wren && app_wdf_rdy) wd_q.push_back(app_wdf_data);
    end

    // Controller model: read data arrives the cycle after the read command is accepted.
    always @(posedge clk) begin
        hs_q = auto_rsp && app_en && app_rdy && (app_cmd == 3'b001);
        #1;
        rsp_valid = hs_q;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ddr2_enable = 1'b0; ddr2_read = 1'b0; ddr2_addr = '0; to_ddr2_data = '0;
        init_calib_complete = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (ddr2_available !== 1'b0) begin failures++; $display("FAIL reset_available got=%b exp=0", ddr2_available); end
        checks++; if (ddr2_data !== 128'h0) begin failures++; $display("FAIL reset_ddr2_data got=%h exp=0", ddr2_data); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (app_en !== 1'b0) begin failures++; $display("FAIL reset_app_en got=%b exp=0", app_en); end
        checks++; if (app_wdf_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b exp=0", app_wdf_wren); end
        checks++; if (app_cmd !== 3'b001) begin failures++; $display("FAIL reset_app_cmd got=%b exp=001", app_cmd); end
        checks++; if (app_addr !== 27'h0) begin failures++; $display("FAIL reset_app_addr got=%h exp=0", app_addr); end
        checks++; if (app_wdf_data !== 128'h0) begin failures++; $display("FAIL reset_wdf_data got=%h exp=0", app_wdf_data); end
        checks++; if (app_wdf_mask !== 16'h0) begin failures++; $display("FAIL reset_wdf_mask got=%h exp=0", app_wdf_mask); end
        checks++; if (app_wdf_end !== 1'b0) begin failures++; $display("FAIL reset_wdf_end got=%b exp=0", app_wdf_end); end
    endtask

    task automatic test_read();
        int lat;
        int pbase;
        init_calib_complete = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1; auto_rsp = 1'b1;
        rsp_data = {16{8'hA5}};
        pbase = pulse_cnt;
        lat = -1;
        ddr2_enable = 1'b1; ddr2_read = 1'b1; ddr2_addr = 27'h0001230;
        tick();
        ddr2_enable = 1'b0; ddr2_read = 1'b0;
        // Strobe cycle is 0; the pulse is expected in cycle 4 (the fifth cycle).
        for (int c = 1; c <= 12; c++) begin
            if (c == 2) begin
                checks++; if (app_en !== 1'b1) begin failures++; $display("FAIL read_app_en got=%b exp=1", app_en); end
                checks++; if (app_cmd !== 3'b001) begin failures++; $display("FAIL read_app_cmd got=%b exp=001", app_cmd); end
                checks++; if (app_addr !== 27'h0000918) begin failures++; $display("FAIL read_app_addr got=%h exp=0000918", app_addr); end
            end
            if (ddr2_available === 1'b1 && lat < 0) begin
                lat = c;
                checks++; if (ddr2_data !== {16{8'hA5}}) begin failures++; $display("FAIL read_data got=%h exp=%h", ddr2_data, {16{8'hA5}}); end
            end
            tick();
        end
        checks++; if (lat !== 4) begin failures++; $display("FAIL read_latency got=%0d exp=4", lat); end
        checks++; if (pulse_cnt - pbase !== 1) begin failures++; $display("FAIL read_pulse_count got=%0d exp=1", pulse_cnt - pbase); end
    endtask

    task automatic test_back_to_back();
        int cbase, wbase, pbase;
        cbase = cmd_q.size(); wbase = wd_q.size(); pbase = pulse_cnt;
        rsp_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        ddr2_enable = 1'b1; ddr2_read = 1'b0; ddr2_addr = 27'h0000040;
        to_ddr2_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        tick();
        ddr2_read = 1'b1; ddr2_addr = 27'h0004040; to_ddr2_data = '0;
        tick();
        ddr2_enable = 1'b0; ddr2_read = 1'b0;
        repeat (15) tick();
        checks++; if (cmd_q.size() - cbase !== 2) begin failures++; $display("FAIL b2b_cmd_count got=%0d exp=2", cmd_q.size() - cbase); end
        checks++; if (cmd_q[cbase] !== {3'b000, 27'h0000020}) begin failures++; $display("FAIL b2b_first_cmd got=%h exp=%h", cmd_q[cbase], {3'b000, 27'h0000020}); end
        checks++; if (cmd_q[cbase+1] !== {3'b001, 27'h0002020}) begin failures++; $display("FAIL b2b_second_cmd got=%h exp=%h", cmd_q[cbase+1], {3'b001, 27'h0002020}); end
        checks++; if (wd_q.size() - wbase !== 1) begin failures++; $display("FAIL b2b_wdata_count got=%0d exp=1", wd_q.size() - wbase); end
        checks++; if (wd_q[wbase] !== 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE) begin failures++; $display("FAIL b2b_wdata got=%h exp=deadbeef0123456789abcdeff00dcafe", wd_q[wbase]); end
        checks++; if (pulse_cnt - pbase !== 1) begin failures++; $display("FAIL b2b_pulse_count got=%0d exp=1", pulse_cnt - pbase); end
        checks++; if (ddr2_data !== 128'h1111_2222_3333_4444_5555_6666_7777_8888) begin failures++; $display("FAIL b2b_rdata got=%h exp=11112222333344445555666677778888", ddr2_data); end
    endtask

    task automatic test_write_stall();
        int cbase, wbase, en_cnt, wren_cnt, end_bad;
        cbase = cmd_q.size(); wbase = wd_q.size();
        en_cnt = 0; wren_cnt = 0; end_bad = 0;
        ddr2_enable = 1'b1; ddr2_read = 1'b0; ddr2_addr = 27'h0000080;
        to_ddr2_data = {4{32'hCAFE_0080}};
        tick();
        ddr2_enable = 1'b0;
        app_rdy = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            if (app_en === 1'b1) en_cnt++;
            if (app_wdf_wren === 1'b1) wren_cnt++;
            if (app_wdf_end !== app_wdf_wren) end_bad++;
            app_rdy = (k >= 3);
            tick();
        end
        app_rdy = 1'b1;
        checks++; if (en_cnt !== 4) begin failures++; $display("FAIL stall_app_en_cycles got=%0d exp=4", en_cnt); end
        checks++; if (wren_cnt !== 1) begin failures++; $display("FAIL stall_wren_cycles got=%0d exp=1", wren_cnt); end
        checks++; if (end_bad !== 0) begin failures++; $display("FAIL stall_wdf_end_cycles got=%0d exp=0", end_bad); end
        checks++; if (cmd_q.size() - cbase !== 1) begin failures++; $display("FAIL stall_cmd_count got=%0d exp=1", cmd_q.size() - cbase); end
        checks++; if (cmd_q[cbase] !== {3'b000, 27'h0000040}) begin failures++; $display("FAIL stall_cmd got=%h exp=%h", cmd_q[cbase], {3'b000, 27'h0000040}); end
        checks++; if (wd_q[wbase] !== {4{32'hCAFE_0080}}) begin failures++; $display("FAIL stall_wdata got=%h exp=%h", wd_q[wbase], {4{32'hCAFE_0080}}); end
    endtask

    task automatic test_overflow();
        logic [26:0]  exp_addr [4];
        logic [127:0] exp_data [4];
        int cbase, wbase, en_seen;
        exp_addr = '{27'h80, 27'h88, 27'h90, 27'h98};
        exp_data = '{{4{32'h1000_0000}}, {4{32'h1000_0001}}, {4{32'h1000_0002}}, {4{32'h1000_0003}}};
        cbase = cmd_q.size(); wbase = wd_q.size(); en_seen = 0;
        init_calib_complete = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ddr2_enable = 1'b1; ddr2_read = 1'b0;
            ddr2_addr = 27'h100 + 27'(i * 16);
            to_ddr2_data = {4{32'h1000_0000 + 32'(i)}};
            tick();
        end
        ddr2_enable = 1'b0;
        repeat (5) begin
            if (app_en === 1'b1) en_seen++;
            tick();
        end
        checks++; if (en_seen !== 0) begin failures++; $display("FAIL ovf_no_issue_uncal got=%0d exp=0", en_seen); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        init_calib_complete = 1'b1;
        repeat (30) tick();
        checks++; if (cmd_q.size() - cbase !== 4) begin failures++; $display("FAIL ovf_cmd_count got=%0d exp=4", cmd_q.size() - cbase); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cmd_q[cbase+i] !== {3'b000, exp_addr[i]}) begin failures++; $display("FAIL ovf_cmd%0d got=%h exp=%h", i, cmd_q[cbase+i], {3'b000, exp_addr[i]}); end
            checks++; if (wd_q[wbase+i] !== exp_data[i]) begin failures++; $display("FAIL ovf_wdata%0d got=%h exp=%h", i, wd_q[wbase+i], exp_data[i]); end
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_reset_rd_wait();
        int cbase, pbase, en_seen;
        auto_rsp = 1'b0; init_calib_complete = 1'b1; app_rdy = 1'b1;
        cbase = cmd_q.size(); pbase = pulse_cnt; en_seen = 0;
        ddr2_enable = 1'b1; ddr2_read = 1'b1; ddr2_addr = 27'h0000200;
        tick();
        ddr2_read = 1'b0; ddr2_addr = 27'h0000300; to_ddr2_data = {8{16'hBEEF}};
        tick();
        ddr2_enable = 1'b0;
        tick();
        checks++; if (app_en !== 1'b0) begin failures++; $display("FAIL rst_rdwait_app_en got=%b exp=0", app_en); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        man_data = {4{32'hBAD0_BAD0}}; man_valid = 1'b1;
        tick();
        man_valid = 1'b0;
        repeat (8) begin
            if (app_en === 1'b1) en_seen++;
            tick();
        end
        checks++; if (pulse_cnt - pbase !== 0) begin failures++; $display("FAIL rst_rdwait_pulses got=%0d exp=0", pulse_cnt - pbase); end
        checks++; if (ddr2_data !== 128'h0) begin failures++; $display("FAIL rst_rdwait_data got=%h exp=0", ddr2_data); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_rdwait_overflow got=%b exp=0", overflow); end
        checks++; if (en_seen !== 0) begin failures++; $display("FAIL rst_rdwait_queue_flushed got=%0d exp=0", en_seen); end
        checks++; if (cmd_q.size() - cbase !== 1) begin failures++; $display("FAIL rst_rdwait_cmd_count got=%0d exp=1", cmd_q.size() - cbase); end
    endtask

    task automatic test_stray_valid();
        auto_rsp = 1'b1; app_rdy = 1'b1;
        rsp_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        ddr2_enable = 1'b1; ddr2_read = 1'b1; ddr2_addr = 27'h0000400;
        tick();
        ddr2_enable = 1'b0; ddr2_read = 1'b0;
        repeat (10) tick();
        checks++; if (ddr2_data !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) begin failures++; $display("FAIL stray_setup_data got=%h exp=0123456789abcdeffedcba9876543210", ddr2_data); end
        man_data = '1; man_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (ddr2_available !== 1'b0) begin failures++; $display("FAIL stray_available%0d got=%b exp=0", k, ddr2_available); end
        end
        man_valid = 1'b0;
        tick();
        checks++; if (ddr2_data !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) begin failures++; $display("FAIL stray_data got=%h exp=0123456789abcdeffedcba9876543210", ddr2_data); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_back_to_back();
        test_write_stall();
        test_overflow();
        test_reset_rd_wait();
        test_stray_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
